// File: rtl/merge_pkg.sv
// Shared defaults and types for the row merge block (lane buffers plus drain FSM).
package vrsm_pkg;
  localparam int DATA_WIDTH    = 32;
  localparam int BURST_LENGTH  = 32;
  localparam int KERNEL_LENGTH = 3;

  typedef enum logic {FILL, DRAIN} merge_state_t;
  typedef logic [DATA_WIDTH-1:0] word_t;
endpackage

// File: rtl/merge_lane_buf.sv
// Single-lane burst memory with a write port and a registered read port.
// The mem_checker port exists only when MERGE_CHECKER_EN is defined.
module merge_lane_buf #(
  parameter int DATA_WIDTH   = vrsm_pkg::DATA_WIDTH,
  parameter int BURST_LENGTH = vrsm_pkg::BURST_LENGTH,
  parameter int AW           = $clog2(BURST_LENGTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
`ifdef MERGE_CHECKER_EN
  output logic [BURST_LENGTH-1:0][DATA_WIDTH-1:0] mem_checker,
`endif
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [BURST_LENGTH-1:0][DATA_WIDTH-1:0] mem;

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

`ifdef MERGE_CHECKER_EN
  assign mem_checker = mem;
`endif

endmodule

// File: rtl/merge.sv
// Row merge: collects KERNEL_LENGTH-wide vectors into per-lane bursts, then drains lane by lane.
// Define MERGE_CHECKER_EN to expose internal state on *_checker ports.
//
// state | meaning
// FILL  | accepting write vectors into all lanes at wptr; reads ignored
// DRAIN | popping lane_sel[rptr] on each read; writes ignored
module merge #(
  parameter int DATA_WIDTH    = vrsm_pkg::DATA_WIDTH,
  parameter int BURST_LENGTH  = vrsm_pkg::BURST_LENGTH,
  parameter int KERNEL_LENGTH = vrsm_pkg::KERNEL_LENGTH,
  parameter int PW            = $clog2(BURST_LENGTH),
  parameter int LSW           = (KERNEL_LENGTH > 1) ? $clog2(KERNEL_LENGTH) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wen,
  input  logic [KERNEL_LENGTH*DATA_WIDTH-1:0] din,
  output logic                              full_flag,
  input  logic                              ren,
  output logic [DATA_WIDTH-1:0]             dout,
  output logic                              valid,
  output logic                              last,
`ifdef MERGE_CHECKER_EN
  output logic [PW-1:0]                     wptr_checker,
  output logic [PW-1:0]                     rptr_checker,
  output logic [LSW-1:0]                    lane_sel_checker,
  output logic                              state_checker,
  output logic [KERNEL_LENGTH-1:0][BURST_LENGTH-1:0][DATA_WIDTH-1:0] buf_checker,
`endif
  output logic                              empty_flag
);
  import vrsm_pkg::*;

  merge_state_t          state;
  logic [PW-1:0]         wptr, rptr;
  logic [LSW-1:0]        lane_sel, lane_q;
  logic                  lane_we, drain_rd;
  logic [DATA_WIDTH-1:0] lane_rdata [KERNEL_LENGTH];

  assign lane_we  = rst && (state == FILL)  && wen;
  assign drain_rd = rst && (state == DRAIN) && ren;

  for (genvar l = 0; l < KERNEL_LENGTH; l++) begin : g_lane
    merge_lane_buf #(
      .DATA_WIDTH  (DATA_WIDTH),
      .BURST_LENGTH(BURST_LENGTH)
    ) u_buf (
      .clk  (clk),
      .rst  (rst),
      .we   (lane_we),
      .waddr(wptr),
      .wdata(din[l*DATA_WIDTH +: DATA_WIDTH]),
      .re   (drain_rd && (lane_sel == LSW'(l))),
      .raddr(rptr),
`ifdef MERGE_CHECKER_EN
      .mem_checker(buf_checker[l]),
`endif
      .rdata(lane_rdata[l])
    );
  end

  // lane_q remembers which lane produced the registered word, since lane_sel may already have moved on.
  assign dout = lane_rdata[lane_q];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= FILL;
      wptr       <= '0;
      rptr       <= '0;
      lane_sel   <= '0;
      lane_q     <= '0;
      valid      <= 1'b0;
      last       <= 1'b0;
      full_flag  <= 1'b0;
      empty_flag <= 1'b1;
    end else begin
      case (state)
        FILL: begin
          valid <= 1'b0;
          last  <= 1'b0;
          if (wen) begin
            wptr <= wptr + 1'b1;
            if (wptr == PW'(BURST_LENGTH - 1)) begin
              state      <= DRAIN;
              full_flag  <= 1'b1;
              empty_flag <= 1'b0;
            end
          end
        end
        DRAIN: begin
          valid <= ren;
          last  <= ren && (rptr == PW'(BURST_LENGTH - 1));
          if (ren) begin
            lane_q <= lane_sel;
            rptr   <= rptr + 1'b1;
            if (rptr == PW'(BURST_LENGTH - 1)) begin
              if (lane_sel == LSW'(KERNEL_LENGTH - 1)) begin
                lane_sel   <= '0;
                state      <= FILL;
                full_flag  <= 1'b0;
                empty_flag <= 1'b1;
              end else begin
                lane_sel <= lane_sel + 1'b1;
              end
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

`ifdef MERGE_CHECKER_EN
  assign wptr_checker     = wptr;
  assign rptr_checker     = rptr;
  assign lane_sel_checker = lane_sel;
  assign state_checker    = (state == DRAIN);
`endif

endmodule

// File: tb/tb_merge.sv
// Testbench for merge: directed scenarios with literal expectations plus random traffic against a burst-level model.
module tb_merge;
  localparam int DW = 32;
  localparam int BL = 32;
  localparam int KL = 3;
  localparam int PW = $clog2(BL);
  localparam int LSW = (KL > 1) ? $clog2(KL) : 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic wen = 1'b0;
  logic ren = 1'b0;
  logic [KL*DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic valid, last, full_flag, empty_flag;
`ifdef MERGE_CHECKER_EN
  logic [PW-1:0] wptr_checker, rptr_checker;
  logic [LSW-1:0] lane_sel_checker;
  logic state_checker;
  logic [KL-1:0][BL-1:0][DW-1:0] buf_checker;
`endif

  merge #(.DATA_WIDTH(DW), .BURST_LENGTH(BL), .KERNEL_LENGTH(KL)) dut (
    .clk(clk), .rst(rst), .wen(wen), .din(din), .full_flag(full_flag),
    .ren(ren), .dout(dout), .valid(valid), .last(last),
`ifdef MERGE_CHECKER_EN
    .wptr_checker(wptr_checker), .rptr_checker(rptr_checker),
    .lane_sel_checker(lane_sel_checker), .state_checker(state_checker),
    .buf_checker(buf_checker),
`endif
    .empty_flag(empty_flag)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Burst-level model: words written so far, words drained so far, and which phase we are in.
  logic [DW-1:0] m_mem [KL][BL];
  int m_wr = 0;
  int m_rd = 0;
  bit m_draining = 0;
  logic [DW-1:0] e_dout = '0;
  bit e_valid = 0, e_last = 0;
  bit chk_en = 0;

  task automatic model_step();
    if (!rst) begin
      m_wr = 0; m_rd = 0; m_draining = 0;
      e_dout = '0; e_valid = 0; e_last = 0;
    end else if (!m_draining) begin
      e_valid = 0; e_last = 0;
      if (wen) begin
        for (int l = 0; l < KL; l++) m_mem[l][m_wr] = din[l*DW +: DW];
        m_wr++;
        if (m_wr == BL) begin m_wr = 0; m_draining = 1; end
      end
    end else if (ren) begin
      e_dout  = m_mem[m_rd / BL][m_rd % BL];
      e_valid = 1;
      e_last  = (m_rd % BL) == BL - 1;
      m_rd++;
      if (m_rd == KL * BL) begin m_rd = 0; m_draining = 0; end
    end else begin
      e_valid = 0; e_last = 0;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("dout", dout, e_dout);
      chk("valid", DW'(valid), DW'(e_valid));
      chk("last", DW'(last), DW'(e_last));
      chk("full_flag", DW'(full_flag), DW'(m_draining));
      chk("empty_flag", DW'(empty_flag), DW'(!m_draining));
    end
  end

  task automatic cycle(input bit r_n, input bit w, input logic [KL*DW-1:0] d, input bit rd);
    rst = r_n; wen = w; din = d; ren = rd;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  function automatic logic [KL*DW-1:0] vec(input int i, input int off);
    logic [KL*DW-1:0] v;
    for (int l = 0; l < KL; l++) v[l*DW +: DW] = DW'(l * 100 + i + 1 + off);
    return v;
  endfunction

  task automatic fill(input int off);
    for (int i = 0; i < BL; i++) begin
      cycle(1, 1, vec(i, off), 0);
      chk("full_after_write", DW'(full_flag), DW'(i == BL - 1));
    end
  endtask

  // Drains a full burst set; gap=1 inserts an idle cycle after every read.
  task automatic drain_literal(input int off, input bit gap);
    int k = 0;
    int lasts = 0;
    logic [DW-1:0] prev = '0;
    while (k < KL * BL) begin
      cycle(1, 0, '0, 1);
      prev = DW'((k / BL) * 100 + (k % BL) + 1 + off);
      chk("drain_dout", dout, prev);
      chk("drain_valid", DW'(valid), 1);
      chk("drain_last", DW'(last), DW'((k % BL) == BL - 1));
      chk("drain_empty", DW'(empty_flag), DW'(k == KL * BL - 1));
      if (last) lasts++;
      k++;
      if (gap && k < KL * BL) begin
        cycle(1, 0, '0, 0);
        chk("gap_valid", DW'(valid), 0);
        chk("gap_dout_hold", dout, prev);
      end
    end
    chk("last_count", DW'(lasts), DW'(KL));
  endtask

  initial begin
    cycle(0, 0, '0, 0);
    cycle(0, 0, '0, 0);
    chk("rst_dout", dout, 0);
    chk("rst_valid", DW'(valid), 0);
    chk("rst_last", DW'(last), 0);
    chk("rst_full", DW'(full_flag), 0);
    chk("rst_empty", DW'(empty_flag), 1);
    chk_en = 1;

    // Basic fill then continuous drain
    fill(0);
    drain_literal(0, 0);

    // Writes during DRAIN are dropped
    fill(0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 1, {KL{32'hDEAD}}, 0);
      chk("drain_wen_full", DW'(full_flag), 1);
    end
    drain_literal(0, 0);

    // Gapped reads
    fill(0);
    drain_literal(0, 1);

    // Reads during FILL are dropped
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0, '0, 1);
      chk("fill_ren_valid", DW'(valid), 0);
    end
    fill(10);
    drain_literal(10, 0);

    // Reset mid-drain, then a fresh set starts at lane 0 word 0
    fill(0);
    for (int i = 0; i < 40; i++) cycle(1, 0, '0, 1);
    cycle(0, 0, '0, 1);
    chk("mid_rst_empty", DW'(empty_flag), 1);
    chk("mid_rst_full", DW'(full_flag), 0);
    chk("mid_rst_valid", DW'(valid), 0);
    chk("mid_rst_dout", dout, 0);
    fill(50);
    drain_literal(50, 0);

    // Random traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      logic [KL*DW-1:0] d;
      for (int l = 0; l < KL; l++) d[l*DW +: DW] = $urandom;
      cycle($urandom_range(0, 299) != 0, $urandom_range(0, 1) == 1, d, $urandom_range(0, 3) != 0);
    end

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
